// File: rtl/mem_stage_lsu_pkg.sv
// mem_stage_lsu_pkg: stall encodings, load opcodes and load FSM states shared by the MEM stage
package mem_stage_lsu_pkg;
  localparam logic STOP = 1'b1;
  localparam logic NO_STOP = 1'b0;
  typedef enum logic [2:0] {LD_NONE, LD_B, LD_BU, LD_H, LD_HU, LD_W, LD_WU, LD_D} ld_op_e;
  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_e;
endpackage

// File: rtl/mem_load_align.sv
// mem_load_align: lane select, sign/zero extension and misalignment detection for loads
module mem_load_align import mem_stage_lsu_pkg::*; #(
  parameter int DATA_W = 32
) (
  input  logic [2:0]        ld_op,
  input  logic [2:0]        addr,
  input  logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] data,
  output logic              misalign
);
  localparam int OW = DATA_W == 64 ? 3 : 2;
  logic [DATA_W-1:0] sh;
  assign sh = rdata >> {addr[OW-1:0], 3'b000};
  assign misalign = (ld_op inside {LD_H, LD_HU}) ? addr[0] :
                    (ld_op inside {LD_W, LD_WU}) ? |addr[1:0] :
                    (ld_op == LD_D) ? |addr : 1'b0;
  assign data = ld_op == LD_B  ? DATA_W'($signed(sh[7:0])) :
                ld_op == LD_BU ? DATA_W'(sh[7:0]) :
                ld_op == LD_H  ? DATA_W'($signed(sh[15:0])) :
                ld_op == LD_HU ? DATA_W'(sh[15:0]) :
                ld_op == LD_W  ? DATA_W'($signed(sh[31:0])) :
                ld_op == LD_WU ? DATA_W'(sh[31:0]) : sh;
endmodule

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: MEM pipeline stage with variable-latency load completion, alignment and forwarding
module mem_stage_lsu import mem_stage_lsu_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int RF_AW = 5,
  parameter int STALL_W = 6,
  parameter int STAGE_IDX = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [STALL_W-1:0]  stall,
  input  logic                ex_valid,
  input  logic [31:0]         ex_pc,
  input  logic                ex_mem_en,
  input  logic [DATA_W/8-1:0] ex_mem_wen,
  input  logic [2:0]          ex_ld_op,
  input  logic                ex_rf_we,
  input  logic [RF_AW-1:0]    ex_rf_waddr,
  input  logic [DATA_W-1:0]   ex_result,
  input  logic                data_sram_rvalid,
  input  logic [DATA_W-1:0]   data_sram_rdata,
  output logic                stallreq,
  output logic                misalign,
  output logic [31:0]         wb_pc,
  output logic                wb_we,
  output logic [RF_AW-1:0]    wb_waddr,
  output logic [DATA_W-1:0]   wb_wdata,
  output logic                fwd_we,
  output logic [RF_AW-1:0]    fwd_waddr,
  output logic [DATA_W-1:0]   fwd_wdata,
  output logic                fwd_ld_pending
);
  logic valid_q, mem_en_q, rf_we_q;
  logic [31:0] pc_q;
  logic [DATA_W/8-1:0] wen_q;
  logic [2:0] ld_op_q;
  logic [RF_AW-1:0] waddr_q;
  logic [DATA_W-1:0] result_q, hold_q, hold_d, ld_data, aligned;
  state_e state_q, state_d;
  logic is_load, mis, ld, go, bubble, stall_unused;
  assign go = stall[STAGE_IDX] == NO_STOP;
  assign bubble = stall[STAGE_IDX] == STOP && stall[STAGE_IDX+1] == NO_STOP;
  assign stall_unused = ^stall;
  always_ff @(posedge clk or negedge rst)
    if (!rst) {valid_q, pc_q, mem_en_q, wen_q, ld_op_q, rf_we_q, waddr_q, result_q} <= '0;
    else if (bubble) {valid_q, pc_q, mem_en_q, wen_q, ld_op_q, rf_we_q, waddr_q, result_q} <= '0;
    else if (go) {valid_q, pc_q, mem_en_q, wen_q, ld_op_q, rf_we_q, waddr_q, result_q} <=
      {ex_valid, ex_pc, ex_mem_en, ex_mem_wen, ex_ld_op, ex_rf_we, ex_rf_waddr, ex_result};
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      hold_q <= '0;
    end else begin
      state_q <= state_d;
      hold_q <= hold_d;
    end
  assign is_load = valid_q & mem_en_q & ~|wen_q & |ld_op_q;
  assign ld = is_load & ~mis;
  // Returned data is parked in hold_q whenever the stage cannot advance on the rvalid cycle
  always_comb begin
    state_d = state_q;
    hold_d = hold_q;
    case (state_q)
      IDLE: if (ld && data_sram_rvalid && !go) begin
        hold_d = data_sram_rdata;
        state_d = HOLD;
      end else if (ld && !data_sram_rvalid) state_d = WAIT;
      WAIT: if (data_sram_rvalid) begin
        hold_d = data_sram_rdata;
        state_d = go ? IDLE : HOLD;
      end
      HOLD: if (go) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  assign stallreq = ld & (((state_q == IDLE) & ~data_sram_rvalid) | (state_q == WAIT));
  assign ld_data = state_q == HOLD ? hold_q : data_sram_rdata;
  mem_load_align #(.DATA_W(DATA_W)) u_align (
    .ld_op(ld_op_q),
    .addr(result_q[2:0]),
    .rdata(ld_data),
    .data(aligned),
    .misalign(mis)
  );
  assign misalign = is_load & mis;
  assign wb_wdata = misalign ? '0 : is_load ? aligned : result_q;
  assign wb_we = rf_we_q & ~stallreq & ~misalign;
  assign wb_pc = pc_q;
  assign wb_waddr = waddr_q;
  assign fwd_we = rf_we_q & ~misalign;
  assign fwd_waddr = waddr_q;
  assign fwd_wdata = wb_wdata;
  assign fwd_ld_pending = stallreq;
endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu: directed vector table plus multi-cycle sequences for the MEM stage
module tb_mem_stage_lsu;
  localparam logic [5:0] S_HOLD = 6'b011000;
  localparam logic [5:0] S_BUB = 6'b001000;
  logic clk, rst;
  logic [5:0] stall;
  logic ex_valid, ex_mem_en, ex_rf_we, rvalid;
  logic [31:0] ex_pc, ex_result, rdata;
  logic [3:0] ex_mem_wen;
  logic [2:0] ex_ld_op;
  logic [4:0] ex_rf_waddr;
  logic stallreq, misalign, wb_we, fwd_we, fwd_ld_pending;
  logic [31:0] wb_pc, wb_wdata, fwd_wdata;
  logic [4:0] wb_waddr, fwd_waddr;
  logic [7:0] d_wen;
  logic [63:0] d_result, d_rdata, d_wb_wdata, d_fwd_wdata;
  logic d_stallreq, d_misalign, d_wb_we, d_fwd_we, d_fwd_ld_pending;
  logic [31:0] d_wb_pc;
  logic [4:0] d_wb_waddr, d_fwd_waddr;
  int errors = 0, checks = 0;

  mem_stage_lsu dut (
    .clk(clk), .rst(rst), .stall(stall), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_mem_en(ex_mem_en), .ex_mem_wen(ex_mem_wen), .ex_ld_op(ex_ld_op), .ex_rf_we(ex_rf_we),
    .ex_rf_waddr(ex_rf_waddr), .ex_result(ex_result), .data_sram_rvalid(rvalid),
    .data_sram_rdata(rdata), .stallreq(stallreq), .misalign(misalign), .wb_pc(wb_pc),
    .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata), .fwd_we(fwd_we),
    .fwd_waddr(fwd_waddr), .fwd_wdata(fwd_wdata), .fwd_ld_pending(fwd_ld_pending)
  );
  mem_stage_lsu #(.DATA_W(64)) dut64 (
    .clk(clk), .rst(rst), .stall(stall), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_mem_en(ex_mem_en), .ex_mem_wen(d_wen), .ex_ld_op(ex_ld_op), .ex_rf_we(ex_rf_we),
    .ex_rf_waddr(ex_rf_waddr), .ex_result(d_result), .data_sram_rvalid(rvalid),
    .data_sram_rdata(d_rdata), .stallreq(d_stallreq), .misalign(d_misalign), .wb_pc(d_wb_pc),
    .wb_we(d_wb_we), .wb_waddr(d_wb_waddr), .wb_wdata(d_wb_wdata), .fwd_we(d_fwd_we),
    .fwd_waddr(d_fwd_waddr), .fwd_wdata(d_fwd_wdata), .fwd_ld_pending(d_fwd_ld_pending)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] op; logic mem_en; logic [3:0] wen; logic rf_we; logic [31:0] addr;
    logic rv; logic [31:0] rd;
    logic e_sr; logic e_mis; logic e_we; logic e_fwe; logic [31:0] e_wd;
  } vec_t;
  vec_t v[13];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic idle_ex();
    ex_valid = 0; ex_pc = 0; ex_mem_en = 0; ex_mem_wen = 0; ex_ld_op = 0; ex_rf_we = 0;
    ex_rf_waddr = 0; ex_result = 0; d_wen = 0; d_result = 0;
  endtask

  task automatic drive(input logic [2:0] op, input logic men, input logic [3:0] wen,
                       input logic we, input logic [4:0] wa, input logic [31:0] addr,
                       input logic [31:0] pc);
    ex_valid = 1; ex_ld_op = op; ex_mem_en = men; ex_mem_wen = wen; ex_rf_we = we;
    ex_rf_waddr = wa; ex_result = addr; ex_pc = pc;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic late_load(input logic [2:0] op, input logic [31:0] exp, input string nm);
    drive(op, 1, 0, 1, 5'd3, 32'h1003, 32'h600);
    stall = 0; rvalid = 0;
    tick();
    stall = S_HOLD; idle_ex();
    for (int c = 0; c < 3; c++) begin
      if (c == 2) begin rvalid = 1; rdata = 32'h80123456; end
      @(negedge clk);
      chk($sformatf("%s_stallreq_c%0d", nm, c), stallreq, 1);
      chk($sformatf("%s_pending_c%0d", nm, c), fwd_ld_pending, 1);
      chk($sformatf("%s_we_c%0d", nm, c), wb_we, 0);
      tick();
    end
    rvalid = 0; rdata = 0;
    @(negedge clk);
    chk({nm, "_hold_stallreq"}, stallreq, 0);
    chk({nm, "_hold_we"}, wb_we, 1);
    chk({nm, "_hold_wdata"}, wb_wdata, exp);
    stall = 0;
    tick();
  endtask

  initial begin
    rst = 0; stall = 0; rvalid = 0; rdata = 0; d_rdata = 0; idle_ex();
    v[0]  = '{LW(), 1, 4'h0, 1, 32'h1000, 1, 32'hDEADBEEF, 0, 0, 1, 1, 32'hDEADBEEF};
    v[1]  = '{3'd1, 1, 4'h0, 1, 32'h1003, 1, 32'h80123456, 0, 0, 1, 1, 32'hFFFFFF80};
    v[2]  = '{3'd2, 1, 4'h0, 1, 32'h1003, 1, 32'h80123456, 0, 0, 1, 1, 32'h00000080};
    v[3]  = '{3'd3, 1, 4'h0, 1, 32'h1002, 1, 32'h80123456, 0, 0, 1, 1, 32'hFFFF8012};
    v[4]  = '{3'd4, 1, 4'h0, 1, 32'h1000, 1, 32'h80129876, 0, 0, 1, 1, 32'h00009876};
    v[5]  = '{3'd1, 1, 4'h0, 1, 32'h1001, 1, 32'h11223344, 0, 0, 1, 1, 32'h00000033};
    v[6]  = '{3'd1, 1, 4'h0, 1, 32'h1002, 1, 32'h007F0000, 0, 0, 1, 1, 32'h0000007F};
    v[7]  = '{3'd3, 1, 4'h0, 1, 32'h1001, 0, 32'h0,        0, 1, 0, 0, 32'h0};
    v[8]  = '{3'd5, 1, 4'h0, 1, 32'h1002, 0, 32'h0,        0, 1, 0, 0, 32'h0};
    v[9]  = '{3'd0, 0, 4'h0, 1, 32'hCAFEF00D, 0, 32'h0,    0, 0, 1, 1, 32'hCAFEF00D};
    v[10] = '{3'd0, 1, 4'hF, 0, 32'h2000, 0, 32'h0,        0, 0, 0, 0, 32'h2000};
    v[11] = '{3'd5, 1, 4'h0, 0, 32'h1004, 1, 32'h12345678, 0, 0, 0, 0, 32'h12345678};
    v[12] = '{3'd4, 1, 4'h0, 1, 32'h1002, 1, 32'hFFFF0000, 0, 0, 1, 1, 32'h0000FFFF};
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stallreq", stallreq, 0);
    chk("rst_misalign", misalign, 0);
    chk("rst_wb_we", wb_we, 0);
    chk("rst_wb_wdata", wb_wdata, 0);
    chk("rst_wb_pc", wb_pc, 0);
    chk("rst_fwd_we", fwd_we, 0);
    chk("rst_pending", fwd_ld_pending, 0);
    tick();
    rst = 1;
    for (int i = 0; i < 13; i++) begin
      drive(v[i].op, v[i].mem_en, v[i].wen, v[i].rf_we, 5'(i + 1), v[i].addr, 32'h400 + 32'(i * 4));
      rvalid = 0;
      tick();
      rvalid = v[i].rv; rdata = v[i].rd; idle_ex();
      @(negedge clk);
      chk($sformatf("v%0d_stallreq", i), stallreq, v[i].e_sr);
      chk($sformatf("v%0d_misalign", i), misalign, v[i].e_mis);
      chk($sformatf("v%0d_wb_we", i), wb_we, v[i].e_we);
      chk($sformatf("v%0d_wb_wdata", i), wb_wdata, v[i].e_wd);
      chk($sformatf("v%0d_fwd_we", i), fwd_we, v[i].e_fwe);
      chk($sformatf("v%0d_fwd_wdata", i), fwd_wdata, v[i].e_wd);
      chk($sformatf("v%0d_pending", i), fwd_ld_pending, v[i].e_sr);
      chk($sformatf("v%0d_wb_pc", i), wb_pc, 32'h400 + 32'(i * 4));
      chk($sformatf("v%0d_fwd_waddr", i), fwd_waddr, 5'(i + 1));
      tick();
    end
    rvalid = 0;
    late_load(3'd1, 32'hFFFFFF80, "lb_late");
    late_load(3'd2, 32'h00000080, "lbu_late");
    // rvalid while another stage holds the pipeline
    drive(3'd5, 1, 0, 1, 5'd4, 32'h2000, 32'h700);
    tick();
    stall = S_HOLD; rvalid = 1; rdata = 32'h1234; idle_ex();
    @(negedge clk);
    chk("hold_c0_stallreq", stallreq, 0);
    chk("hold_c0_wdata", wb_wdata, 32'h1234);
    tick();
    rvalid = 0; rdata = 32'h5555;
    @(negedge clk);
    chk("hold_c1_wdata", wb_wdata, 32'h1234);
    chk("hold_c1_we", wb_we, 1);
    tick();
    rdata = 32'h9999; stall = 0;
    @(negedge clk);
    chk("hold_c2_wdata", wb_wdata, 32'h1234);
    tick();
    @(negedge clk);
    chk("hold_adv_we", wb_we, 0);
    chk("hold_adv_wdata", wb_wdata, 0);
    // hold versus bubble
    drive(3'd0, 0, 0, 1, 5'd7, 32'hABCD, 32'h500);
    tick();
    drive(3'd0, 0, 0, 1, 5'd8, 32'h1111, 32'h504);
    stall = S_HOLD;
    @(negedge clk);
    chk("stall_cap_wdata", wb_wdata, 32'hABCD);
    tick();
    stall = S_BUB;
    @(negedge clk);
    chk("stall_hold_wdata", wb_wdata, 32'hABCD);
    chk("stall_hold_waddr", wb_waddr, 5'd7);
    chk("stall_hold_pc", wb_pc, 32'h500);
    tick();
    stall = 0; idle_ex();
    @(negedge clk);
    chk("bubble_wdata", wb_wdata, 0);
    chk("bubble_we", wb_we, 0);
    chk("bubble_fwd_we", fwd_we, 0);
    chk("bubble_pc", wb_pc, 0);
    chk("bubble_waddr", wb_waddr, 0);
    tick();
    // asynchronous reset while waiting
    drive(3'd5, 1, 0, 1, 5'd9, 32'h3000, 32'h800);
    tick();
    stall = S_HOLD; idle_ex();
    @(negedge clk);
    chk("rstw_pre_stallreq", stallreq, 1);
    tick();
    rst = 0;
    #1;
    chk("rstw_stallreq", stallreq, 0);
    chk("rstw_we", wb_we, 0);
    chk("rstw_pc", wb_pc, 0);
    tick();
    rst = 1; stall = 0;
    tick();
    rvalid = 1; rdata = 32'h7777;
    @(negedge clk);
    chk("rstw_late_stallreq", stallreq, 0);
    chk("rstw_late_we", wb_we, 0);
    chk("rstw_late_wdata", wb_wdata, 0);
    tick();
    rvalid = 0;
    drive(3'd0, 0, 0, 1, 5'd2, 32'h55, 32'h900);
    tick();
    idle_ex();
    @(negedge clk);
    chk("rstw_after_wdata", wb_wdata, 32'h55);
    chk("rstw_after_we", wb_we, 1);
    tick();
    // 64-bit datapath
    drive(3'd7, 1, 0, 1, 5'd10, 32'h0, 32'hA00);
    d_result = 64'h8; d_wen = 0;
    tick();
    rvalid = 1; rdata = 0; d_rdata = 64'h0123456789ABCDEF; idle_ex();
    @(negedge clk);
    chk("d64_ld_wdata", d_wb_wdata, 64'h0123456789ABCDEF);
    chk("d64_ld_we", d_wb_we, 1);
    chk("d64_ld_stallreq", d_stallreq, 0);
    tick();
    drive(3'd5, 1, 0, 1, 5'd11, 32'h0, 32'hA04);
    d_result = 64'hC; rvalid = 0;
    tick();
    rvalid = 1; d_rdata = 64'h80000000_11111111; idle_ex();
    @(negedge clk);
    chk("d64_lw_wdata", d_wb_wdata, 64'hFFFFFFFF_80000000);
    tick();
    drive(3'd7, 1, 0, 1, 5'd12, 32'h0, 32'hA08);
    d_result = 64'h4; rvalid = 0;
    tick();
    rvalid = 1; idle_ex();
    @(negedge clk);
    chk("d64_ld_misalign", d_misalign, 1);
    chk("d64_ld_mis_we", d_wb_we, 0);
    tick();
    rvalid = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  function automatic logic [2:0] LW();
    return 3'd5;
  endfunction
endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
Parametrised next-generation MEM pipeline stage. It registers the EX-to-MEM payload under the shared stall bus. It completes loads from a variable-latency data SRAM using an rvalid handshake, and requests a pipeline stall while a load is outstanding. It aligns and sign- or zero-extends sub-word loads, flags misaligned accesses, and drives the WB payload plus a forwarding bus back to ID.

Parameters:
DATA_W, 32, datapath width; legal values 32 or 64.
RF_AW, 5, register-file address width.
STALL_W, 6, width of the stall bus.
STAGE_IDX, 3, this stage's bit in the stall bus; bit STAGE_IDX+1 is the downstream stage.

Ports:
clk  in  1  clock.
rst  in  1  asynchronous, active-low reset.
stall  in  STALL_W  1 = Stop per stage.
ex_valid  in  1  EX payload valid.
ex_pc  in  32  instruction PC.
ex_mem_en  in  1  memory access.
ex_mem_wen  in  DATA_W/8  byte write enables; 0 with mem_en=1 means load.
ex_ld_op  in  3  0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 LWU, 7 LD (6 and 7 legal only when DATA_W=64).
ex_rf_we  in  1  register write.
ex_rf_waddr  in  RF_AW  destination register.
ex_result  in  DATA_W  ALU result, or address for memory operations.
data_sram_rvalid  in  1  read data valid.
data_sram_rdata  in  DATA_W  read data.
stallreq  out  1  MEM requests pipeline stall.
misalign  out  1  current load is misaligned.
wb_pc  out  32  to WB.
wb_we  out  1  to WB.
wb_waddr  out  RF_AW  to WB.
wb_wdata  out  DATA_W  to WB.
fwd_we  out  1  forwarding write enable.
fwd_waddr  out  RF_AW  forwarding destination.
fwd_wdata  out  DATA_W  forwarding value.
fwd_ld_pending  out  1  forwarded value not yet available (ID must stall).

Behaviour:
- Stage register, on every posedge clk:
  - rst low: all fields cleared asynchronously.
  - stall[IDX]=1 and stall[IDX+1]=0: cleared (bubble).
  - stall[IDX]=0: captures the ex_* inputs.
  - otherwise: holds.
- Load definition: is_load = valid & mem_en & (mem_wen==0) & (ld_op!=0).
- Stores and non-memory operations complete in zero added cycles.
- Load FSM states: IDLE, WAIT, HOLD. Reset state is IDLE.
  - IDLE, is_load, rvalid=0 → WAIT.
  - IDLE, is_load, rvalid=1 → use rdata directly. Stay IDLE if stall[IDX]=0; otherwise latch rdata into hold_q and go to HOLD.
  - WAIT, rvalid=1 → latch hold_q; go to HOLD, or to IDLE if stall[IDX]=0 in the same cycle.
  - HOLD → IDLE when stall[IDX]=0 (the register advances).
  - rvalid seen in IDLE with no load, or in HOLD, is ignored.
- stallreq = is_load & ((IDLE & !rvalid) | WAIT). It is combinational and never asserted for stores.
- Load data source: hold_q in HOLD, otherwise data_sram_rdata.
- Lane selection by result[2:0] (64-bit) or result[1:0] (32-bit).
  - B/BU pick the byte at the offset; H/HU pick the halfword; W/WU pick the word.
  - Signed ops sign-extend to DATA_W; unsigned ops zero-extend.
- Misalignment: H with addr[0]≠0, W with addr[1:0]≠0, or D with addr[2:0]≠0 sets misalign=1. In that case wb_we=0, fwd_we=0, wdata=0, and no wait or stall is requested.
- wb_wdata = load ? aligned_data : result. wb_we = rf_we & !stallreq & !misalign.
- Forwarding bus:
  - fwd_we = rf_we & !misalign.
  - fwd_waddr = waddr.
  - fwd_wdata = result for non-loads, aligned data once available.
  - fwd_ld_pending = stallreq.
- Reset values: every output is 0, including stallreq.
- Asynchronous reset mid-WAIT: FSM returns to IDLE and hold_q clears; a late rvalid is then ignored.

Decomposition:
- Shared package (lib/defines): stall encodings Stop/NoStop, ld_op codes, FSM state encodings.
- One sub-module, mem_load_align: combinational lane select and extension with misalign detection, parametrised by DATA_W.

Test Plan:
1. LW at addr 0x1000, rvalid in the same cycle, rdata=0xDEADBEEF → stallreq never 1; wb_we=1, wb_wdata=0xDEADBEEF.
2. LB at addr 0x1003, rvalid 3 cycles late, rdata=0x80123456 → stallreq=1 for 3 cycles and fwd_ld_pending=1; then wb_wdata=0xFFFFFF80. LBU with the same stimulus → 0x00000080.
3. LH at addr 0x1001 → misalign=1, wb_we=0, stallreq=0.
4. rvalid arrives while stall[IDX] is held by another stage for 2 cycles, rdata=0x1234 → FSM in HOLD; wb_wdata stays 0x1234 even after rdata changes, until the register advances.
5. stall[3]=1, stall[4]=0 for 1 cycle → next cycle all outputs 0 (bubble). stall[3]=stall[4]=1 → outputs unchanged.
6. rst pulled low during WAIT, rvalid follows after release → outputs 0, state IDLE, late rvalid ignored. DATA_W=64 with LD at addr 0x8 → 64-bit rdata passed through.
